// File: rtl/updown_seq_pkg.sv
// Shared encodings for the up/down count sequencer: command modes and FSM states.
package updown_seq_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN_UP   = 2'd1,
    S_RUN_DOWN = 2'd2,
    S_DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/updown_count_core.sv
// N-bit up/down counter; load has priority over count enable, dir=1 counts up.
module updown_count_core #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  input  logic         dir,
  output logic [N-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= dir ? count + N'(1) : count - N'(1);
    end
  end

endmodule

// File: rtl/updown_count_sequencer.sv
// Runs an up/down counter through up, down or bounce programs with a done/err pulse.
// Optional UPDOWN_SEQ_ABORT_EN adds an abort input that ends a running program early.
module updown_count_sequencer #(
  parameter int N     = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef UPDOWN_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [N-1:0]     cfg_lo,
  input  logic [N-1:0]     cfg_hi,
  input  logic [1:0]       cfg_mode,
  input  logic [REP_W-1:0] cfg_repeat,
  output logic [N-1:0]     count,
  output logic             up_or_down,
  output logic             busy,
  output logic             done,
  output logic             err
);
  import updown_seq_pkg::*;

  state_t           state, state_nxt;
  mode_t            mode_q;
  logic [N-1:0]     lo_q, hi_q;
  logic [REP_W-1:0] pass_q, pass_nxt;
  logic             dir_q, dir_nxt;
  logic             err_q, err_nxt;
  logic             load, en, cnt_up;
  logic [N-1:0]     load_val;
  logic             abort_hit;

`ifdef UPDOWN_SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  updown_count_core #(.N(N)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .dir      (cnt_up),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      dir_q  <= 1'b1;
      err_q  <= 1'b0;
      pass_q <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      mode_q <= MODE_UP;
    end else begin
      state  <= state_nxt;
      dir_q  <= dir_nxt;
      err_q  <= err_nxt;
      pass_q <= pass_nxt;
      if (state == S_IDLE && start_valid) begin
        lo_q   <= cfg_lo;
        hi_q   <= cfg_hi;
        mode_q <= mode_t'(cfg_mode);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir_q;
    err_nxt   = err_q;
    pass_nxt  = pass_q;
    load      = 1'b0;
    load_val  = count;
    en        = 1'b0;
    cnt_up    = dir_q;
    unique case (state)
      S_IDLE: begin
        if (start_valid) begin
          if (cfg_lo > cfg_hi || cfg_mode == MODE_RSVD) begin
            state_nxt = S_DONE;
            err_nxt   = 1'b1;
          end else begin
            err_nxt  = 1'b0;
            load     = 1'b1;
            pass_nxt = (cfg_repeat == '0) ? REP_W'(1) : cfg_repeat;
            if (cfg_mode == MODE_DOWN) begin
              load_val  = cfg_hi;
              dir_nxt   = 1'b0;
              state_nxt = S_RUN_DOWN;
            end else begin
              load_val  = cfg_lo;
              dir_nxt   = 1'b1;
              state_nxt = S_RUN_UP;
            end
          end
        end
      end
      S_RUN_UP: begin
        if (abort_hit) begin
          state_nxt = S_DONE;
          err_nxt   = 1'b1;
        end else if (count == hi_q) begin
          // A degenerate lo==hi bounce has no turn-around step.
          if (mode_q == MODE_BOUNCE && lo_q != hi_q) begin
            load      = 1'b1;
            load_val  = hi_q - N'(1);
            dir_nxt   = 1'b0;
            state_nxt = S_RUN_DOWN;
          end else begin
            state_nxt = S_DONE;
          end
        end else begin
          en     = 1'b1;
          cnt_up = 1'b1;
        end
      end
      S_RUN_DOWN: begin
        if (abort_hit) begin
          state_nxt = S_DONE;
          err_nxt   = 1'b1;
        end else if (count == lo_q) begin
          if (mode_q == MODE_BOUNCE && pass_q > REP_W'(1)) begin
            pass_nxt  = pass_q - REP_W'(1);
            load      = 1'b1;
            load_val  = lo_q + N'(1);
            dir_nxt   = 1'b1;
            state_nxt = S_RUN_UP;
          end else begin
            state_nxt = S_DONE;
          end
        end else begin
          en     = 1'b1;
          cnt_up = 1'b0;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign start_ready = (state == S_IDLE);
  assign busy        = (state == S_RUN_UP) || (state == S_RUN_DOWN);
  assign done        = (state == S_DONE);
  assign err         = (state == S_DONE) && err_q;
  assign up_or_down  = dir_q;

endmodule

// File: tb/tb_updown_count_sequencer.sv
// Bench for updown_count_sequencer: a sequence-level model fills a per-cycle expectation queue.
module tb_updown_count_sequencer;
  localparam int N = 4;
  localparam int REP_W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_valid = 1'b0;
  logic [3:0] cfg_lo = '0, cfg_hi = '0, cfg_repeat = '0;
  logic [1:0] cfg_mode = '0;
  logic       start_ready, up_or_down, busy, done, err;
  logic [3:0] count;
`ifdef UPDOWN_SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif

  always #5 clk = ~clk;

  updown_count_sequencer #(.N(N), .REP_W(REP_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef UPDOWN_SEQ_ABORT_EN
    .abort       (abort),
`endif
    .start_valid (start_valid),
    .start_ready (start_ready),
    .cfg_lo      (cfg_lo),
    .cfg_hi      (cfg_hi),
    .cfg_mode    (cfg_mode),
    .cfg_repeat  (cfg_repeat),
    .count       (count),
    .up_or_down  (up_or_down),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  typedef struct packed {
    logic       rdy;
    logic       bsy;
    logic       dn;
    logic       er;
    logic       dir;
    logic [3:0] cnt;
  } ent_t;

  ent_t       exq[$];
  logic [3:0] m_count = '0;
  logic       m_dir = 1'b1;
  bit         chk_en = 1'b0;
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  function automatic void push(logic r, logic b, logic d, logic e, logic dr, logic [3:0] c);
    ent_t x;
    x.rdy = r; x.bsy = b; x.dn = d; x.er = e; x.dir = dr; x.cnt = c;
    exq.push_back(x);
    m_count = c;
    m_dir   = dr;
  endfunction

  // One idle cycle while the command is offered, then the visible count sequence, then done.
  function automatic void model_cmd(int lo, int hi, int mode, int rep);
    int p = (rep == 0) ? 1 : rep;
    push(1, 0, 0, 0, m_dir, m_count);
    if (lo > hi || mode == 3) begin
      push(0, 0, 1, 1, m_dir, m_count);
      return;
    end
    if (mode == 0) begin
      for (int v = lo; v <= hi; v++) push(0, 1, 0, 0, 1, 4'(v));
    end else if (mode == 1) begin
      for (int v = hi; v >= lo; v--) push(0, 1, 0, 0, 0, 4'(v));
    end else if (lo == hi) begin
      push(0, 1, 0, 0, 1, 4'(lo));
    end else begin
      for (int ps = 1; ps <= p; ps++) begin
        for (int v = (ps == 1) ? lo : lo + 1; v <= hi; v++) push(0, 1, 0, 0, 1, 4'(v));
        for (int v = hi - 1; v >= lo; v--) push(0, 1, 0, 0, 0, 4'(v));
      end
    end
    push(0, 0, 1, 0, m_dir, m_count);
  endfunction

  always @(negedge clk) begin : cmp
    ent_t e, g;
    if (chk_en) begin
      if (exq.size() > 0) e = exq.pop_front();
      else begin
        e.rdy = 1; e.bsy = 0; e.dn = 0; e.er = 0; e.dir = m_dir; e.cnt = m_count;
      end
      e.er = e.dn & e.er;
      g = {start_ready, busy, done, done & err, up_or_down, count};
      check("cycle{rdy,busy,done,err,dir,cnt}", 32'(g), 32'(e));
    end
  end

  task automatic present(input int lo, input int hi, input int mode, input int rep);
    cfg_lo = 4'(lo); cfg_hi = 4'(hi); cfg_mode = 2'(mode); cfg_repeat = 4'(rep);
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (exq.size() > 0 && k < 200);
    #1;
    if (exq.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout t=%0t left=%0d exp=0", $time, exq.size());
      exq.delete();
    end
  endtask

  task automatic run(input int lo, input int hi, input int mode, input int rep);
    model_cmd(lo, hi, mode, rep);
    present(lo, hi, mode, rep);
    drain();
  endtask

  initial begin
    int pin[9] = '{0, 1, 2, 1, 0, 1, 2, 1, 0};
    int len1;

    // Pin the model against hand-derived sequences.
    model_cmd(0, 2, 2, 2);
    check("model_bounce_len", 32'(exq.size()), 32'd11);
    for (int i = 0; i < 9; i++) check("model_bounce_cnt", 32'(exq[i+1].cnt), 32'(pin[i]));
    check("model_bounce_done", 32'(exq[10].dn), 32'd1);
    exq.delete();
    model_cmd(9, 4, 0, 0);
    check("model_reject_len", 32'(exq.size()), 32'd2);
    check("model_reject_err", 32'(exq[1].er), 32'd1);
    exq.delete();
    m_count = '0;
    m_dir   = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_dir", 32'(up_or_down), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(start_ready), 32'd1);
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(3, 6, 0, 0);
    check("up_final_count", 32'(count), 32'd6);
    run(13, 15, 1, 0);
    check("down_final_dir", 32'(up_or_down), 32'd0);
    run(0, 2, 2, 2);
    run(13, 15, 2, 0);
    run(0, 15, 2, 1);
    run(12, 15, 0, 0);
    run(0, 2, 1, 0);
    run(9, 4, 0, 0);
    run(1, 5, 3, 0);
    run(7, 7, 0, 0);
    run(7, 7, 2, 3);
    run(7, 7, 1, 0);

    // Reset for two edges in the middle of a bounce.
    model_cmd(0, 3, 2, 3);
    present(0, 3, 2, 3);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    exq.delete();
    m_count = '0;
    m_dir   = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // start_valid held through a program: the second command waits for idle.
    model_cmd(2, 4, 0, 0);
    len1 = exq.size();
    model_cmd(5, 6, 1, 0);
    present(2, 4, 0, 0);
    cfg_lo = 4'd5; cfg_hi = 4'd6; cfg_mode = 2'd1; cfg_repeat = 4'd0;
    start_valid = 1'b1;
    repeat (len1) @(posedge clk);
    #1 start_valid = 1'b0;
    drain();

`ifdef UPDOWN_SEQ_ABORT_EN
    abort = 1'b1;
    repeat (2) @(posedge clk);
    #1 abort = 1'b0;
    push(1, 0, 0, 0, m_dir, m_count);
    for (int v = 2; v <= 5; v++) push(0, 1, 0, 0, 1, 4'(v));
    push(0, 0, 1, 1, 1, 4'd5);
    present(2, 10, 0, 0);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    drain();
    check("abort_count", 32'(count), 32'd5);
`endif

    repeat (2) @(posedge clk);
    #1 chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
